spi_cfg_sequencer: RTL and testbench

Table-driven SPI configuration sequencer for DAC/ADC/clock-chip bring-up; replaces hard-coded per-register state chains with a command table (external synchronous ROM) interpreted by one fixed FSM. Drives the existing single-transaction SPI engine (spi_wr_rd_single) over a valid/ready handshake. Adds parametrised address/data widths, timed delays, read-poll with mask/expect and bounded retries, hardware reset pulse, and error reporting.

---
 rtl/spi_cfg_pkg.sv | 49 ++++
 rtl/spi_cfg_cmd_rom.sv | 25 ++
 rtl/spi_cfg_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_spi_cfg_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - shared constants and command-word helpers for the SPI config sequencer
package spi_cfg_pkg;

  typedef enum logic [3:0] {
    OP_WRITE = 4'h0,
    OP_POLL  = 4'h1,
    OP_DELAY = 4'h2,
    OP_HWRST = 4'h3,
    OP_END   = 4'hF
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_RST_H,
    S_RST_L,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] SPI_WRITE_MODE = 2'b00;
  localparam logic [1:0] SPI_READ_MODE  = 2'b01;
  localparam logic [1:0] SPI_DELAY_MODE = 2'b10;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_POLL_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL_OP   = 2'b10;
  localparam logic [1:0] ERR_OVERRUN      = 2'b11;

  // Command words are handled zero-extended to 64 bits so the helpers stay width-agnostic.
  function automatic logic [3:0] cmd_op(input logic [63:0] w, input int unsigned cmd_w);
    return 4'(w >> (cmd_w - 4));
  endfunction

  function automatic logic [63:0] cmd_field(input logic [63:0] w, input int unsigned lsb,
                                            input int unsigned width);
    return (w >> lsb) & ((64'(1) << width) - 64'(1));
  endfunction

  function automatic logic masked_match(input logic [31:0] rd, input logic [31:0] expv,
                                        input logic [31:0] mask);
    return ((rd ^ expv) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/spi_cfg_cmd_rom.sv
// rtl/spi_cfg_cmd_rom.sv - command table storage with one-cycle registered read
// Contents are written through the load port at bring-up for the target device.
module spi_cfg_cmd_rom #(
  parameter int DEPTH = 64,
  parameter int CMD_W = 27,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [CMD_W-1:0] load_word,
  input  logic [IDX_W-1:0] cmd_idx,
  output logic [CMD_W-1:0] cmd_word
);

  logic [CMD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (load_en) begin
      mem[load_idx] <= load_word;
    end
    cmd_word <= mem[cmd_idx];
  end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// rtl/spi_cfg_sequencer.sv - table-driven SPI bring-up sequencer driving a single-transaction engine
// One fixed FSM interprets WRITE/POLL/DELAY/HWRST/END commands fetched from an external table.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 64,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int POLL_MAX = 16,
  parameter int CMD_W    = 4 + ADDR_W + 2 * DATA_W
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 err_code,
  output logic [IDX_W-1:0]           err_idx,
  output logic                       o_reset,
  output logic [IDX_W-1:0]           cmd_idx,
  input  logic [CMD_W-1:0]           cmd_word,
  output logic                       spi_valid,
  input  logic                       spi_ready,
  output logic [1:0]                 spi_mode,
  output logic [ADDR_W+DATA_W:0]     spi_wr_infodata,
  output logic [ADDR_W:0]            spi_rd_info,
  input  logic [DATA_W-1:0]          spi_rd_data,
  output logic [2*DATA_W-1:0]        spi_delay_cnt
);

  localparam int CNT_W   = 2 * DATA_W;
  localparam int RETRY_W = $clog2(POLL_MAX + 1);
  localparam int unsigned POLL_LIMIT = POLL_MAX;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e                  state_q, state_nxt;
  logic [IDX_W-1:0]        cmd_idx_q, cmd_idx_nxt;
  logic                    busy_q, busy_nxt;
  logic                    done_q, done_nxt;
  logic                    error_q, error_nxt;
  logic [1:0]              err_code_q, err_code_nxt;
  logic [IDX_W-1:0]        err_idx_q, err_idx_nxt;
  logic                    o_reset_q, o_reset_nxt;
  logic                    spi_valid_q, spi_valid_nxt;
  logic [1:0]              spi_mode_q, spi_mode_nxt;
  logic [ADDR_W+DATA_W:0]  wr_info_q, wr_info_nxt;
  logic [ADDR_W:0]         rd_info_q, rd_info_nxt;
  logic [CNT_W-1:0]        delay_q, delay_nxt;
  logic [CMD_W-1:0]        cmd_q, cmd_nxt;
  logic [DATA_W-1:0]       rd_q, rd_nxt;
  logic [RETRY_W-1:0]      retry_q, retry_nxt;
  logic [CNT_W-1:0]        hw_cnt_q, hw_cnt_nxt;

  logic [3:0]              fetched_op, op_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       data_q, mask_q;
  logic [CNT_W-1:0]        count_q, hw_len;
  logic                    poll_ok;

  assign fetched_op = cmd_op(64'(cmd_word), CMD_W);
  assign op_q       = cmd_op(64'(cmd_q), CMD_W);
  assign addr_q     = ADDR_W'(cmd_field(64'(cmd_q), 2 * DATA_W, ADDR_W));
  assign data_q     = DATA_W'(cmd_field(64'(cmd_q), DATA_W, DATA_W));
  assign mask_q     = cmd_q[DATA_W-1:0];
  assign count_q    = cmd_q[CNT_W-1:0];
  // A zero reset-phase length still holds each phase for one cycle.
  assign hw_len     = (count_q == '0) ? CNT_W'(1) : count_q;
  assign poll_ok    = masked_match(32'(rd_q), 32'(data_q), 32'(mask_q));

  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign err_code        = err_code_q;
  assign err_idx         = err_idx_q;
  assign o_reset         = o_reset_q;
  assign cmd_idx         = cmd_idx_q;
  assign spi_valid       = spi_valid_q;
  assign spi_mode        = spi_mode_q;
  assign spi_wr_infodata = wr_info_q;
  assign spi_rd_info     = rd_info_q;
  assign spi_delay_cnt   = delay_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_idx_q   <= '0;
      o_reset_q   <= 1'b0;
      spi_valid_q <= 1'b0;
      spi_mode_q  <= SPI_WRITE_MODE;
      wr_info_q   <= '0;
      rd_info_q   <= '0;
      delay_q     <= '0;
      cmd_q       <= '0;
      rd_q        <= '0;
      retry_q     <= '0;
      hw_cnt_q    <= '0;
    end else begin
      state_q     <= state_nxt;
      cmd_idx_q   <= cmd_idx_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      error_q     <= error_nxt;
      err_code_q  <= err_code_nxt;
      err_idx_q   <= err_idx_nxt;
      o_reset_q   <= o_reset_nxt;
      spi_valid_q <= spi_valid_nxt;
      spi_mode_q  <= spi_mode_nxt;
      wr_info_q   <= wr_info_nxt;
      rd_info_q   <= rd_info_nxt;
      delay_q     <= delay_nxt;
      cmd_q       <= cmd_nxt;
      rd_q        <= rd_nxt;
      retry_q     <= retry_nxt;
      hw_cnt_q    <= hw_cnt_nxt;
    end
  end

  logic       adv;
  logic       err_go;
  logic [1:0] err_sel;

  always_comb begin
    state_nxt     = state_q;
    cmd_idx_nxt   = cmd_idx_q;
    busy_nxt      = busy_q;
    done_nxt      = 1'b0;
    error_nxt     = error_q;
    err_code_nxt  = err_code_q;
    err_idx_nxt   = err_idx_q;
    o_reset_nxt   = o_reset_q;
    spi_valid_nxt = spi_valid_q;
    spi_mode_nxt  = spi_mode_q;
    wr_info_nxt   = wr_info_q;
    rd_info_nxt   = rd_info_q;
    delay_nxt     = delay_q;
    cmd_nxt       = cmd_q;
    rd_nxt        = rd_q;
    retry_nxt     = retry_q;
    hw_cnt_nxt    = hw_cnt_q;
    adv           = 1'b0;
    err_go        = 1'b0;
    err_sel       = ERR_NONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_nxt     = 1'b1;
          error_nxt    = 1'b0;
          err_code_nxt = ERR_NONE;
          cmd_idx_nxt  = '0;
          state_nxt    = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        cmd_nxt   = cmd_word;
        retry_nxt = '0;
        case (fetched_op)
          OP_WRITE, OP_POLL, OP_DELAY: state_nxt = S_ISSUE;
          OP_HWRST: begin
            hw_cnt_nxt  = '0;
            o_reset_nxt = 1'b1;
            state_nxt   = S_RST_H;
          end
          OP_END:  state_nxt = S_DONE;
          default: begin
            err_go  = 1'b1;
            err_sel = ERR_ILLEGAL_OP;
          end
        endcase
      end
      S_ISSUE: begin
        spi_valid_nxt = 1'b1;
        state_nxt     = S_WAIT;
        case (op_q)
          OP_POLL: begin
            spi_mode_nxt = SPI_READ_MODE;
            rd_info_nxt  = {1'b1, addr_q};
          end
          OP_DELAY: begin
            spi_mode_nxt = SPI_DELAY_MODE;
            delay_nxt    = count_q;
          end
          default: begin
            spi_mode_nxt = SPI_WRITE_MODE;
            wr_info_nxt  = {1'b0, addr_q, data_q};
          end
        endcase
      end
      S_WAIT: begin
        if (spi_ready) begin
          spi_valid_nxt = 1'b0;
          if (op_q == OP_POLL) begin
            rd_nxt    = spi_rd_data;
            state_nxt = S_CHECK;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (poll_ok) begin
          adv = 1'b1;
        end else if (32'(retry_q) + 32'd1 < POLL_LIMIT) begin
          retry_nxt = retry_q + RETRY_W'(1);
          state_nxt = S_ISSUE;
        end else begin
          err_go  = 1'b1;
          err_sel = ERR_POLL_TIMEOUT;
        end
      end
      S_RST_H: begin
        if (hw_cnt_q == hw_len - CNT_W'(1)) begin
          hw_cnt_nxt  = '0;
          o_reset_nxt = 1'b0;
          state_nxt   = S_RST_L;
        end else begin
          hw_cnt_nxt = hw_cnt_q + CNT_W'(1);
        end
      end
      S_RST_L: begin
        if (hw_cnt_q == hw_len - CNT_W'(1)) begin
          hw_cnt_nxt = '0;
          adv        = 1'b1;
        end else begin
          hw_cnt_nxt = hw_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        done_nxt    = 1'b1;
        busy_nxt    = 1'b0;
        o_reset_nxt = 1'b0;
        state_nxt   = S_IDLE;
      end
      S_ERR: begin
        error_nxt     = 1'b1;
        err_idx_nxt   = cmd_idx_q;
        busy_nxt      = 1'b0;
        spi_valid_nxt = 1'b0;
        o_reset_nxt   = 1'b0;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Running off the end of the table without an END is reported rather than wrapped.
    if (adv) begin
      if (cmd_idx_q == LAST_IDX) begin
        err_go  = 1'b1;
        err_sel = ERR_OVERRUN;
      end else begin
        cmd_idx_nxt = cmd_idx_q + IDX_W'(1);
        state_nxt   = S_FETCH;
      end
    end

    if (err_go) begin
      state_nxt    = S_ERR;
      err_code_nxt = err_sel;
    end
  end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb/tb_spi_cfg_sequencer.sv - scoreboard bench for spi_cfg_sequencer with a small table and engine model
module tb_spi_cfg_sequencer;
  import spi_cfg_pkg::*;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int IDX_W    = 2;
  localparam int POLL_MAX = 4;
  localparam int CMD_W    = 4 + ADDR_W + 2 * DATA_W;

  logic                   clk_in = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   busy, done, error, o_reset, spi_valid;
  logic                   spi_ready = 1'b0;
  logic [1:0]             err_code, spi_mode;
  logic [IDX_W-1:0]       err_idx, cmd_idx;
  logic [CMD_W-1:0]       cmd_word;
  logic [ADDR_W+DATA_W:0] spi_wr_infodata;
  logic [ADDR_W:0]        spi_rd_info;
  logic [DATA_W-1:0]      spi_rd_data = '0;
  logic [2*DATA_W-1:0]    spi_delay_cnt;
  logic                   load_en;
  logic [IDX_W-1:0]       load_idx;
  logic [CMD_W-1:0]       load_word;

  always #5 clk_in = ~clk_in;

  spi_cfg_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
    .POLL_MAX(POLL_MAX), .CMD_W(CMD_W)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .err_idx(err_idx), .o_reset(o_reset),
    .cmd_idx(cmd_idx), .cmd_word(cmd_word), .spi_valid(spi_valid),
    .spi_ready(spi_ready), .spi_mode(spi_mode), .spi_wr_infodata(spi_wr_infodata),
    .spi_rd_info(spi_rd_info), .spi_rd_data(spi_rd_data), .spi_delay_cnt(spi_delay_cnt)
  );

  spi_cfg_cmd_rom #(.DEPTH(DEPTH), .CMD_W(CMD_W), .IDX_W(IDX_W)) rom (
    .clk_in(clk_in), .load_en(load_en), .load_idx(load_idx), .load_word(load_word),
    .cmd_idx(cmd_idx), .cmd_word(cmd_word)
  );

  typedef struct { logic [1:0] mode; logic [15:0] payload; } txn_t;
  typedef struct { logic err; logic [1:0] code; logic [IDX_W-1:0] idx; } res_t;

  txn_t       exp_q[$];
  res_t       res_q[$];
  logic [7:0] poll_q[$];
  int         checks = 0;
  int         failures = 0;
  bit         eng_hold = 1'b0;
  int         eng_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(input logic [3:0] op, input logic [6:0] addr,
                                          input logic [7:0] data, input logic [7:0] mask);
    return {op, addr, data, mask};
  endfunction

  function automatic txn_t tx(input logic [1:0] mode, input logic [15:0] payload);
    txn_t t;
    t.mode = mode;
    t.payload = payload;
    return t;
  endfunction

  function automatic res_t rs(input logic err, input logic [1:0] code, input logic [IDX_W-1:0] idx);
    res_t r;
    r.err = err;
    r.code = code;
    r.idx = idx;
    return r;
  endfunction

  // Engine model: completes each request on its second valid cycle.
  always @(negedge clk_in) begin
    spi_ready = 1'b0;
    if (!rst_n || !spi_valid || eng_hold) begin
      eng_cnt = 0;
    end else begin
      eng_cnt++;
      if (eng_cnt == 2) begin
        spi_ready = 1'b1;
        spi_rd_data = (poll_q.size() != 0) ? poll_q.pop_front() : 8'h00;
      end
    end
  end

  logic valid_d = 1'b0;
  always @(negedge clk_in) begin : txn_monitor
    txn_t e;
    logic [15:0] act;
    if (spi_valid && !valid_d) begin
      case (spi_mode)
        SPI_WRITE_MODE: act = spi_wr_infodata;
        SPI_READ_MODE:  act = {8'h00, spi_rd_info};
        default:        act = spi_delay_cnt;
      endcase
      if (exp_q.size() == 0) begin
        check("txn_unexpected", {spi_mode, act}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("txn_mode", spi_mode, e.mode);
        check("txn_payload", act, e.payload);
      end
    end
    valid_d = spi_valid;
  end

  logic error_d = 1'b0;
  always @(negedge clk_in) begin : res_monitor
    res_t r;
    if (done || (error && !error_d)) begin
      if (res_q.size() == 0) begin
        check("res_unexpected", {done, error}, 64'h0);
      end else begin
        r = res_q.pop_front();
        check("res_error", error, r.err);
        check("res_done", done, !r.err);
        if (r.err) begin
          check("res_err_code", err_code, r.code);
          check("res_err_idx", err_idx, r.idx);
        end
      end
    end
    error_d = error;
  end

  task automatic load_table(input logic [CMD_W-1:0] w0, input logic [CMD_W-1:0] w1,
                            input logic [CMD_W-1:0] w2, input logic [CMD_W-1:0] w3);
    logic [CMD_W-1:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      load_en = 1'b1;
      load_idx = IDX_W'(i);
      load_word = w[i];
    end
    @(negedge clk_in);
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic finish_seq(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_timeout"}, 64'(n >= 300), 64'h0);
    repeat (3) @(negedge clk_in);
    check({tag, "_txn_left"}, 64'(exp_q.size()), 64'h0);
    check({tag, "_res_left"}, 64'(res_q.size()), 64'h0);
    check({tag, "_poll_left"}, 64'(poll_q.size()), 64'h0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctrl"}, 64'({busy, done, error, err_code, err_idx, o_reset, cmd_idx,
                               spi_valid, spi_mode}), 64'h0);
    check({tag, "_data"}, 64'({spi_wr_infodata, spi_rd_info, spi_delay_cnt}), 64'h0);
  endtask

  initial begin
    int n, hi, lo;
    rst_n = 1'b0;
    start = 1'b0;
    load_en = 1'b0;
    load_idx = '0;
    load_word = '0;
    repeat (3) @(negedge clk_in);
    check_reset("reset");
    rst_n = 1'b1;

    load_table(mk(OP_WRITE, 7'h00, 8'h20, 8'h00), mk(OP_WRITE, 7'h1C, 8'h04, 8'h00),
               mk(OP_END, 7'h00, 8'h00, 8'h00), mk(OP_END, 7'h00, 8'h00, 8'h00));
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h0020));
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h1C04));
    res_q.push_back(rs(1'b0, ERR_NONE, 2'd0));
    pulse_start();
    finish_seq("writes");

    load_table(mk(OP_POLL, 7'h18, 8'h07, 8'h07), mk(OP_END, 7'h00, 8'h00, 8'h00),
               mk(OP_END, 7'h00, 8'h00, 8'h00), mk(OP_END, 7'h00, 8'h00, 8'h00));
    poll_q = '{8'h03, 8'h03, 8'h07};
    for (int i = 0; i < 3; i++) exp_q.push_back(tx(SPI_READ_MODE, 16'h0098));
    res_q.push_back(rs(1'b0, ERR_NONE, 2'd0));
    pulse_start();
    finish_seq("poll_ok");

    load_table(mk(OP_WRITE, 7'h01, 8'h55, 8'h00), mk(OP_POLL, 7'h18, 8'h07, 8'h07),
               mk(OP_END, 7'h00, 8'h00, 8'h00), mk(OP_END, 7'h00, 8'h00, 8'h00));
    poll_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h0155));
    for (int i = 0; i < 4; i++) exp_q.push_back(tx(SPI_READ_MODE, 16'h0098));
    res_q.push_back(rs(1'b1, ERR_POLL_TIMEOUT, 2'd1));
    pulse_start();
    finish_seq("poll_timeout");

    load_table(mk(OP_HWRST, 7'h00, 8'h00, 8'h0A), mk(OP_DELAY, 7'h00, 8'h01, 8'h23),
               mk(OP_END, 7'h00, 8'h00, 8'h00), mk(OP_END, 7'h00, 8'h00, 8'h00));
    exp_q.push_back(tx(SPI_DELAY_MODE, 16'h0123));
    res_q.push_back(rs(1'b0, ERR_NONE, 2'd0));
    pulse_start();
    check("start_clears_error", 64'({error, err_code}), 64'h0);
    n = 0;
    while (!o_reset && n < 50) begin @(negedge clk_in); n++; end
    hi = 0;
    while (o_reset && hi < 50) begin @(negedge clk_in); hi++; end
    lo = 0;
    while (!o_reset && cmd_idx == 2'd0 && lo < 50) begin @(negedge clk_in); lo++; end
    check("hwrst_high_cycles", 64'(hi), 64'd10);
    check("hwrst_low_cycles", 64'(lo), 64'd10);
    check("hwrst_next_idx", 64'(cmd_idx), 64'd1);
    finish_seq("hwrst");

    load_table(mk(OP_WRITE, 7'h02, 8'h11, 8'h00), mk(OP_WRITE, 7'h03, 8'h22, 8'h00),
               mk(4'h7, 7'h00, 8'h00, 8'h00), mk(OP_END, 7'h00, 8'h00, 8'h00));
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h0211));
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h0322));
    res_q.push_back(rs(1'b1, ERR_ILLEGAL_OP, 2'd2));
    pulse_start();
    finish_seq("illegal");

    load_table(mk(OP_WRITE, 7'h04, 8'h01, 8'h00), mk(OP_WRITE, 7'h05, 8'h02, 8'h00),
               mk(OP_WRITE, 7'h06, 8'h03, 8'h00), mk(OP_WRITE, 7'h07, 8'h04, 8'h00));
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h0401));
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h0502));
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h0603));
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h0704));
    res_q.push_back(rs(1'b1, ERR_OVERRUN, 2'd3));
    pulse_start();
    repeat (3) @(negedge clk_in);
    pulse_start();
    finish_seq("overrun");

    load_table(mk(OP_WRITE, 7'h0A, 8'h5A, 8'h00), mk(OP_END, 7'h00, 8'h00, 8'h00),
               mk(OP_END, 7'h00, 8'h00, 8'h00), mk(OP_END, 7'h00, 8'h00, 8'h00));
    eng_hold = 1'b1;
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h0A5A));
    pulse_start();
    n = 0;
    while (!spi_valid && n < 50) begin @(negedge clk_in); n++; end
    check("rst_valid_seen", 64'(spi_valid), 64'h1);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b0;
    @(negedge clk_in);
    check_reset("midrun_reset");
    rst_n = 1'b1;
    eng_hold = 1'b0;
    exp_q.push_back(tx(SPI_WRITE_MODE, 16'h0A5A));
    res_q.push_back(rs(1'b0, ERR_NONE, 2'd0));
    pulse_start();
    check("rerun_idx", 64'({busy, cmd_idx}), 64'h4);
    finish_seq("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
